// File: rtl/scs8hd_nandnb_pipe.sv
// Multi-lane NAND with per-input inversion mask and a 2-entry elastic output buffer.
// Each lane reduces WIDTH inputs; mode flips NAND to AND before the result is buffered.

module scs8hd_nandnb_lane #(
    parameter int              WIDTH    = 3,
    parameter logic [WIDTH-1:0] INV_MASK = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic [WIDTH-1:0] a,
    input  logic             mode,
    output logic             r
);
    assign r = ~(&(a ^ INV_MASK)) ^ mode;
endmodule

module scs8hd_nandnb_pipe #(
    parameter int              WIDTH    = 3,
    parameter int              LANES    = 4,
    parameter logic [WIDTH-1:0] INV_MASK = {{(WIDTH-1){1'b0}}, 1'b1}
) (
`ifdef SC_USE_PG_PIN
    input  logic                   vpwr,
    input  logic                   vgnd,
    input  logic                   vpb,
    input  logic                   vnb,
`endif
    input  logic                   CLK,
    input  logic                   RESETB,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       Y,
    output logic [15:0]            txn_cnt
);
    typedef struct packed {
        logic [LANES*WIDTH-1:0] data;
        logic                   mode;
    } req_t;

    req_t             req;
    logic [LANES-1:0] r;
    logic [LANES-1:0] mem [2];
    logic [1:0]       cnt, cnt_n;
    logic             wp, rp, rp_n;
    logic             accept, pop;
    logic [LANES-1:0] head_n, y_n;

    assign req = '{data: in_data, mode: mode};

    // Instance array splits req.data into WIDTH-bit slices, lane 0 at the LSBs.
    scs8hd_nandnb_lane #(.WIDTH(WIDTH), .INV_MASK(INV_MASK)) u_lane [LANES-1:0] (
        .a    (req.data),
        .mode (req.mode),
        .r    (r)
    );

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        cnt_n = cnt;
        case ({accept, pop})
            2'b10:   cnt_n = cnt + 2'd1;
            2'b01:   cnt_n = cnt - 2'd1;
            default: cnt_n = cnt;
        endcase
        rp_n = rp ^ pop;
        // A write landing on the new head bypasses the buffer so Y sees it in one cycle.
        head_n = (accept && (wp == rp_n)) ? r : mem[rp_n];
        y_n    = (cnt_n != 2'd0) ? head_n : Y;
    end

    always_ff @(posedge CLK) begin
        if (accept) mem[wp] <= r;
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            cnt     <= 2'd0;
            wp      <= 1'b0;
            rp      <= 1'b0;
            Y       <= '0;
            txn_cnt <= 16'd0;
        end else begin
            cnt <= cnt_n;
            rp  <= rp_n;
            Y   <= y_n;
            if (accept) begin
                wp      <= ~wp;
                txn_cnt <= txn_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_scs8hd_nandnb_pipe.sv
// Scoreboard bench for scs8hd_nandnb_pipe at default parameters (WIDTH=3, LANES=4, INV_MASK=3'b001).
module tb_scs8hd_nandnb_pipe;
    logic        CLK = 1'b0;
    logic        RESETB;
    logic        in_valid, in_ready, mode, out_valid, out_ready;
    logic [11:0] in_data;
    logic [3:0]  Y;
    logic [15:0] txn_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  q[$];
    logic [3:0]  popped[$];
    logic [3:0]  last_y = 4'd0;
    logic [15:0] txn_exp = 16'd0;
    logic [3:0]  sb_y;
    logic        sb_rdy, sb_vld;

    scs8hd_nandnb_pipe dut (
        .CLK(CLK), .RESETB(RESETB), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .Y(Y), .txn_cnt(txn_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] model(input logic [11:0] d, input logic m);
        logic [3:0] f;
        logic [2:0] e;
        for (int l = 0; l < 4; l++) begin
            e    = d[l*3 +: 3] ^ 3'b001;
            f[l] = ~(&e) ^ m;
        end
        return f;
    endfunction

    // Scoreboard: handshakes decided from the model occupancy, checked before the next edge.
    always @(negedge CLK) begin
        if (RESETB === 1'b1) begin
            sb_y   = (q.size() != 0) ? q[0] : last_y;
            sb_rdy = (q.size() != 2);
            sb_vld = (q.size() != 0);
            vectors += 4;
            if (Y !== sb_y) begin
                miscompares++; $display("FAIL sb_y: got %b want %b at %0t", Y, sb_y, $time);
            end
            if (in_ready !== sb_rdy) begin
                miscompares++; $display("FAIL sb_in_ready: got %b want %b at %0t", in_ready, sb_rdy, $time);
            end
            if (out_valid !== sb_vld) begin
                miscompares++; $display("FAIL sb_out_valid: got %b want %b at %0t", out_valid, sb_vld, $time);
            end
            if (txn_cnt !== txn_exp) begin
                miscompares++; $display("FAIL sb_txn_cnt: got %0d want %0d at %0t", txn_cnt, txn_exp, $time);
            end
            if (sb_vld && out_ready) begin
                last_y = q.pop_front();
                popped.push_back(Y);
            end
            if (in_valid && sb_rdy) begin
                q.push_back(model(in_data, mode));
                txn_exp = txn_exp + 16'd1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Called at posedge+1; the reset pulse ends before the following negedge.
    task automatic do_reset();
        RESETB = 1'b0;
        #2;
        q.delete(); popped.delete();
        last_y = 4'd0; txn_exp = 16'd0;
        RESETB = 1'b1;
    endtask

    task automatic test_reset();
        RESETB = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 12'h0; mode = 1'b0;
        #3;
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        if (Y !== 4'd0)         begin miscompares++; $display("FAIL rst_y: got %b want 0000", Y); end
        if (txn_cnt !== 16'd0)  begin miscompares++; $display("FAIL rst_txn_cnt: got %0d want 0", txn_cnt); end
        tick(2);
        RESETB = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        in_valid = 1'b1; in_data = 12'hC3E; mode = 1'b0; out_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        vectors += 3;
        if (Y !== 4'b0110)     begin miscompares++; $display("FAIL basic_y: got %b want 0110", Y); end
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        if (txn_cnt !== 16'd1) begin miscompares++; $display("FAIL basic_txn_cnt: got %0d want 1", txn_cnt); end
        tick(2);
    endtask

    task automatic test_and_hold();
        do_reset();
        in_valid = 1'b1; in_data = 12'hC3E; mode = 1'b1; out_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        vectors++;
        if (Y !== 4'b1001) begin miscompares++; $display("FAIL and_y: got %b want 1001", Y); end
        tick(3);
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL empty_out_valid: got %b want 0", out_valid); end
        if (Y !== 4'b1001)      begin miscompares++; $display("FAIL empty_hold_y: got %b want 1001", Y); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 12'hC3E; mode = 1'b0; tick(1);
        in_data = 12'h000; mode = 1'b0; tick(1);
        vectors += 2;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        if (Y !== 4'b0110)     begin miscompares++; $display("FAIL bp_head_y: got %b want 0110", Y); end
        in_data = 12'($urandom); mode = 1'($urandom); tick(2);
        in_data = 12'hFFF; mode = 1'b1; tick(1);
        vectors++;
        if (txn_cnt !== 16'd2) begin miscompares++; $display("FAIL bp_held_txn: got %0d want 2", txn_cnt); end
        out_ready = 1'b1;
        tick(2);
        in_valid = 1'b0;
        tick(3);
        vectors += 3;
        if (popped.size() !== 3) begin
            miscompares++; $display("FAIL bp_pop_count: got %0d want 3", popped.size());
        end else if (popped[0] !== 4'b0110 || popped[1] !== 4'b1111 || popped[2] !== 4'b0000) begin
            miscompares++; $display("FAIL bp_sequence: got %b %b %b want 0110 1111 0000", popped[0], popped[1], popped[2]);
        end
        if (txn_cnt !== 16'd3)  begin miscompares++; $display("FAIL bp_txn_cnt: got %0d want 3", txn_cnt); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 12'($urandom); mode = 1'($urandom);
            tick(1);
            vectors += 2;
            if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_out_valid[%0d]: got %b want 1", i, out_valid); end
        end
        in_valid = 1'b0;
        tick(2);
        vectors += 2;
        if (txn_cnt !== 16'd10)   begin miscompares++; $display("FAIL b2b_txn_cnt: got %0d want 10", txn_cnt); end
        if (popped.size() !== 10) begin miscompares++; $display("FAIL b2b_pops: got %0d want 10", popped.size()); end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 12'hC3E; mode = 1'b1;
        tick(1);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 12'($urandom); mode = 1'($urandom);
            tick(1);
            vectors += 2;
            if (Y !== 4'b1001)      begin miscompares++; $display("FAIL stall_y[%0d]: got %b want 1001", i, Y); end
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
        end
        out_ready = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 12'h5A5; mode = 1'b0;
        tick(2);
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_full: got in_ready %b want 0", in_ready); end
        RESETB = 1'b0;
        #1;
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        if (Y !== 4'd0)         begin miscompares++; $display("FAIL mid_y: got %b want 0000", Y); end
        if (txn_cnt !== 16'd0)  begin miscompares++; $display("FAIL mid_txn_cnt: got %0d want 0", txn_cnt); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        q.delete(); popped.delete(); last_y = 4'd0; txn_exp = 16'd0;
        #2;
        RESETB = 1'b1;
        in_valid = 1'b1; in_data = 12'hC3E; mode = 1'b0; out_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        vectors += 2;
        if (Y !== 4'b0110)     begin miscompares++; $display("FAIL post_rst_y: got %b want 0110", Y); end
        if (txn_cnt !== 16'd1) begin miscompares++; $display("FAIL post_rst_txn: got %0d want 1", txn_cnt); end
        tick(2);
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        repeat (65537) begin
            in_data = 12'($urandom); mode = 1'($urandom);
            tick(1);
        end
        in_valid = 1'b0;
        vectors++;
        if (txn_cnt !== 16'd1) begin miscompares++; $display("FAIL wrap_txn_cnt: got %0d want 1", txn_cnt); end
        tick(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_and_hold();
        test_backpressure();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
